// File: rtl/noise_win_pkg.sv
// Shared definitions for the noise-filter 3x3 window scheduler.
//   PIX_W    : bits per colour / gray sample
//   stateT   : scheduler FSM state encoding
//   ctrW()   : bits needed to hold 0..maxVal (never less than 1)
//   colCtrW(): column counter width, counts 0..IMG_W-1
//   rowCtrW(): row counter width, counts 0..IMG_H+1 (two virtual flush rows)
package noise_win_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } stateT;

  function automatic int ctrW(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

  function automatic int colCtrW(input int imgW);
    return ctrW(imgW - 1);
  endfunction

  // The flush phase walks one full virtual row plus one beat past the frame.
  function automatic int rowCtrW(input int imgH);
    return ctrW(imgH + 1);
  endfunction

endpackage

// File: rtl/noise_window_ctrl_if.sv
// Pixel-in / window-out stream bundle of noise_window_ctrl.
//   Input stream : iSOF, iDVAL, iR, iG, iB, iGray  (no backpressure)
//   Output window: oDVAL, oCen_r/g/b, oW0..oW8 (row-major, oW4 centre),
//                  oBorder, oBusy (input beats ignored while high)
//   modport master : pixel source / window sink side
//   modport slave  : scheduler side
interface noise_window_ctrl_if;
  import noise_win_pkg::*;

  logic             iSOF;
  logic             iDVAL;
  logic [PIX_W-1:0] iR, iG, iB, iGray;

  logic             oDVAL;
  logic [PIX_W-1:0] oCen_r, oCen_g, oCen_b;
  logic [PIX_W-1:0] oW0, oW1, oW2, oW3, oW4, oW5, oW6, oW7, oW8;
  logic             oBorder;
  logic             oBusy;

  modport master (
    output iSOF, iDVAL, iR, iG, iB, iGray,
    input  oDVAL, oCen_r, oCen_g, oCen_b,
    input  oW0, oW1, oW2, oW3, oW4, oW5, oW6, oW7, oW8,
    input  oBorder, oBusy
  );

  modport slave (
    input  iSOF, iDVAL, iR, iG, iB, iGray,
    output oDVAL, oCen_r, oCen_g, oCen_b,
    output oW0, oW1, oW2, oW3, oW4, oW5, oW6, oW7, oW8,
    output oBorder, oBusy
  );

endinterface

// File: rtl/noise_win_linebuf.sv
// Single-clock simple dual-port line buffer with registered read.
//   iCLK    : clock
//   iWrEn   : write strobe, iWrData stored at iWrAddr
//   iRdAddr : read address, oRdData valid the cycle after
// A read and write of the same address in one cycle returns the old word.
module noise_win_linebuf
  import noise_win_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = ctrW(DEPTH - 1)
) (
  input  logic             iCLK,
  input  logic             iWrEn,
  input  logic [AW-1:0]    iWrAddr,
  input  logic [WIDTH-1:0] iWrData,
  input  logic [AW-1:0]    iRdAddr,
  output logic [WIDTH-1:0] oRdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge iCLK) begin
    if (iWrEn) mem[iWrAddr] <= iWrData;
    oRdData <= mem[iRdAddr];
  end

endmodule

// File: rtl/noise_window_ctrl.sv
// Streaming 3x3 gray-window scheduler for the noise-filter stage.
//   iCLK   : pixel clock
//   iRST_N : asynchronous active-low reset
//   bus    : noise_window_ctrl_if.slave (pixel stream in, window out)
// The centre of index k is emitted on the beat that accepts k+IMG_W+1.
// Out-of-image taps are replaced by the centre gray.
// Build option: NOISE_WIN_FLUSH_EN adds the FLUSH state that emits the last
// IMG_W+1 centres after the final input beat; without it those centres are
// dropped and oBusy stays 0.
//
// state | meaning
// IDLE  | waiting for iSOF&iDVAL; other beats dropped
// FILL  | collecting the first IMG_W+1 beats, no windows yet
// RUN   | one window per accepted beat
// FLUSH | virtual beats emit the remaining IMG_W+1 centres, input ignored
module noise_window_ctrl
  import noise_win_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  noise_window_ctrl_if.slave bus
);

  localparam int CW = colCtrW(IMG_W);
  localparam int RW = rowCtrW(IMG_H);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] ROW_TWO   = RW'(2);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FLEND = RW'(IMG_H + 1);

  stateT stateQ, stateD;
  logic [CW-1:0] colQ, colD, bCol, cenCol;
  logic [RW-1:0] rowQ, rowD, bRow, cenRow;
  logic busy, accept, sofBeat, beat, lastCol, emit;

  logic [4*PIX_W-1:0] rdA;
  logic [PIX_W-1:0]   rdB;

  // Two older window columns; the new column comes straight from the buffers.
  logic [PIX_W-1:0]   lTop, lMid, lBot, mTop, mBot;
  logic [4*PIX_W-1:0] mMid;

  logic [PIX_W-1:0] cenGray;
  logic topOut, botOut, leftOut, rightOut;
  logic [PIX_W-1:0] wD [9];
  logic [PIX_W-1:0] wQ [9];
  logic [PIX_W-1:0] cenRQ, cenGQ, cenBQ;
  logic dvalQ, borderQ;

`ifdef NOISE_WIN_FLUSH_EN
  assign busy = (stateQ == FLUSH);
`else
  assign busy = 1'b0;
`endif

  assign accept  = bus.iDVAL & ~busy;
  assign sofBeat = accept & bus.iSOF;

  always_comb begin
    stateD = stateQ;
    beat   = 1'b0;
    bCol   = colQ;
    bRow   = rowQ;
    unique case (stateQ)
      IDLE:      beat = sofBeat;
      FILL, RUN: beat = accept;
      FLUSH:     beat = 1'b1;
    endcase
    // A start-of-frame beat always lands on (0,0), aborting any frame in progress.
    if (sofBeat) begin
      bCol = '0;
      bRow = '0;
    end
    lastCol = (bCol == COL_LAST);
    colD = colQ;
    rowD = rowQ;
    if (beat) begin
      colD = lastCol ? '0 : bCol + COL_ONE;
      rowD = lastCol ? bRow + ROW_ONE : bRow;
    end
    if (sofBeat) begin
      stateD = FILL;
    end else if (beat) begin
      unique case (stateQ)
        FILL: if (bRow == ROW_ONE && bCol == COL_ONE) stateD = RUN;
        RUN: begin
          if (bRow == ROW_LAST && lastCol) begin
`ifdef NOISE_WIN_FLUSH_EN
            stateD = FLUSH;
`else
            stateD = IDLE;
            colD   = '0;
            rowD   = '0;
`endif
          end
        end
        FLUSH: begin
          if (bRow == ROW_FLEND) begin
            stateD = IDLE;
            colD   = '0;
            rowD   = '0;
          end
        end
        default: stateD = stateQ;
      endcase
    end
  end

  // Centre sits one row up and one column left of the beat; a beat at column 0
  // closes the previous line, so its centre is the last column two rows up.
  always_comb begin
    emit = beat && ((bRow >= ROW_TWO) || (bRow == ROW_ONE && bCol != '0));
    if (bCol == '0) begin
      cenCol = COL_LAST;
      cenRow = bRow - ROW_TWO;
    end else begin
      cenCol = bCol - COL_ONE;
      cenRow = bRow - ROW_ONE;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateQ <= IDLE;
      colQ   <= '0;
      rowQ   <= '0;
    end else begin
      stateQ <= stateD;
      colQ   <= colD;
      rowQ   <= rowD;
    end
  end

  // Read address runs one beat ahead so the column is ready when its beat arrives.
  noise_win_linebuf #(.DEPTH(IMG_W), .WIDTH(4*PIX_W), .AW(CW)) uLineA (
    .iCLK   (iCLK),
    .iWrEn  (beat),
    .iWrAddr(bCol),
    .iWrData({bus.iR, bus.iG, bus.iB, bus.iGray}),
    .iRdAddr(colD),
    .oRdData(rdA)
  );

  noise_win_linebuf #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) uLineB (
    .iCLK   (iCLK),
    .iWrEn  (beat),
    .iWrAddr(bCol),
    .iWrData(rdA[PIX_W-1:0]),
    .iRdAddr(colD),
    .oRdData(rdB)
  );

  always_comb begin
    cenGray  = mMid[PIX_W-1:0];
    topOut   = (cenRow == '0);
    botOut   = (cenRow == ROW_LAST);
    leftOut  = (cenCol == '0);
    rightOut = (cenCol == COL_LAST);
    wD[0] = (topOut | leftOut)  ? cenGray : lTop;
    wD[1] = topOut              ? cenGray : mTop;
    wD[2] = (topOut | rightOut) ? cenGray : rdB;
    wD[3] = leftOut             ? cenGray : lMid;
    wD[4] = cenGray;
    wD[5] = rightOut            ? cenGray : rdA[PIX_W-1:0];
    wD[6] = (botOut | leftOut)  ? cenGray : lBot;
    wD[7] = botOut              ? cenGray : mBot;
    wD[8] = (botOut | rightOut) ? cenGray : bus.iGray;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lTop <= '0;
      lMid <= '0;
      lBot <= '0;
      mTop <= '0;
      mMid <= '0;
      mBot <= '0;
    end else if (beat) begin
      lTop <= mTop;
      lMid <= mMid[PIX_W-1:0];
      lBot <= mBot;
      mTop <= rdB;
      mMid <= rdA;
      mBot <= bus.iGray;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dvalQ   <= 1'b0;
      borderQ <= 1'b0;
      cenRQ   <= '0;
      cenGQ   <= '0;
      cenBQ   <= '0;
      for (int t = 0; t < 9; t++) wQ[t] <= '0;
    end else begin
      dvalQ <= emit;
      if (emit) begin
        borderQ <= topOut | botOut | leftOut | rightOut;
        cenRQ   <= mMid[4*PIX_W-1:3*PIX_W];
        cenGQ   <= mMid[3*PIX_W-1:2*PIX_W];
        cenBQ   <= mMid[2*PIX_W-1:PIX_W];
        for (int t = 0; t < 9; t++) wQ[t] <= wD[t];
      end
    end
  end

  assign bus.oDVAL   = dvalQ;
  assign bus.oBorder = borderQ;
  assign bus.oCen_r  = cenRQ;
  assign bus.oCen_g  = cenGQ;
  assign bus.oCen_b  = cenBQ;
  assign bus.oW0     = wQ[0];
  assign bus.oW1     = wQ[1];
  assign bus.oW2     = wQ[2];
  assign bus.oW3     = wQ[3];
  assign bus.oW4     = wQ[4];
  assign bus.oW5     = wQ[5];
  assign bus.oW6     = wQ[6];
  assign bus.oW7     = wQ[7];
  assign bus.oW8     = wQ[8];
  assign bus.oBusy   = busy;

endmodule

// File: tb/tb_noise_window_ctrl.sv
// Directed bench for noise_window_ctrl on a 4x3 image with gray = k and
// RGB = {k, k+1, k+2}. Follows the NOISE_WIN_FLUSH_EN setting of the build.
module tb_noise_window_ctrl;
  import noise_win_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
`ifdef NOISE_WIN_FLUSH_EN
  localparam int NSTROBE = W * H;
  localparam int NBUSY   = W + 1;
`else
  localparam int NSTROBE = W * H - W - 1;
  localparam int NBUSY   = 0;
`endif

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b0;

  noise_window_ctrl_if bus ();

  noise_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .bus   (bus)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int               cyc;
    logic             border;
    logic [7:0]       r, g, b;
    logic [8:0][7:0]  w;
  } strobeT;

  strobeT strobes[$];
  int cycleCnt = 0;
  int busyCnt  = 0;
  int beatEdge [W*H];
  int checks = 0;
  int errors = 0;

  always @(posedge iCLK) cycleCnt <= cycleCnt + 1;

  always @(negedge iCLK) begin
    strobeT s;
    if (bus.oBusy === 1'b1) busyCnt++;
    if (bus.oDVAL === 1'b1) begin
      s.cyc    = cycleCnt;
      s.border = bus.oBorder;
      s.r      = bus.oCen_r;
      s.g      = bus.oCen_g;
      s.b      = bus.oCen_b;
      s.w      = {bus.oW8, bus.oW7, bus.oW6, bus.oW5, bus.oW4,
                  bus.oW3, bus.oW2, bus.oW1, bus.oW0};
      strobes.push_back(s);
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected gray at window tap t for centre k, with out-of-image taps
  // replaced by the centre gray.
  function automatic int tapExp(input int k, input int t);
    int r, c;
    r = k / W + t / 3 - 1;
    c = k % W + t % 3 - 1;
    if (r < 0 || r >= H || c < 0 || c >= W) return k;
    return r * W + c;
  endfunction

  task automatic checkWin(input string tag, input int idx, input int k);
    int bord;
    if (idx >= strobes.size()) begin
      checkVal({tag, "_present"}, strobes.size(), idx + 1);
      return;
    end
    for (int t = 0; t < 9; t++)
      checkVal($sformatf("%s_w%0d", tag, t), 32'(strobes[idx].w[t]), tapExp(k, t));
    checkVal({tag, "_cenR"}, 32'(strobes[idx].r), k);
    checkVal({tag, "_cenG"}, 32'(strobes[idx].g), k + 1);
    checkVal({tag, "_cenB"}, 32'(strobes[idx].b), k + 2);
    bord = (k / W == 0 || k / W == H - 1 || k % W == 0 || k % W == W - 1) ? 1 : 0;
    checkVal({tag, "_border"}, 32'(strobes[idx].border), bord);
  endtask

  task automatic checkHand(input string tag, input int idx, input logic [8:0][7:0] expW,
                           input int k, input logic expBorder);
    if (idx >= strobes.size()) begin
      checkVal({tag, "_present"}, strobes.size(), idx + 1);
      return;
    end
    for (int t = 0; t < 9; t++)
      checkVal($sformatf("%s_w%0d", tag, t), 32'(strobes[idx].w[t]), 32'(expW[t]));
    checkVal({tag, "_cenR"}, 32'(strobes[idx].r), k);
    checkVal({tag, "_cenG"}, 32'(strobes[idx].g), k + 1);
    checkVal({tag, "_cenB"}, 32'(strobes[idx].b), k + 2);
    checkVal({tag, "_border"}, 32'(strobes[idx].border), 32'(expBorder));
  endtask

  task automatic drive(input logic v, input logic s, input int k);
    @(negedge iCLK);
    bus.iDVAL = v;
    bus.iSOF  = s;
    bus.iGray = 8'(k);
    bus.iR    = 8'(k);
    bus.iG    = 8'(k + 1);
    bus.iB    = 8'(k + 2);
    if (v && k < W * H) beatEdge[k] = cycleCnt + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0);
  endtask

  task automatic sendFrame(input logic gap);
    for (int k = 0; k < W * H; k++) begin
      drive(1'b1, k == 0, k);
      if (gap) drive(1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    int base;
    int bb;
    bus.iSOF  = 1'b0;
    bus.iDVAL = 1'b0;
    bus.iR    = '0;
    bus.iG    = '0;
    bus.iB    = '0;
    bus.iGray = '0;

    // Reset values
    repeat (3) @(negedge iCLK);
    checkVal("rst_oDVAL", 32'(bus.oDVAL), 0);
    checkVal("rst_oBusy", 32'(bus.oBusy), 0);
    checkVal("rst_oBorder", 32'(bus.oBorder), 0);
    checkVal("rst_oW4", 32'(bus.oW4), 0);
    checkVal("rst_oCen_b", 32'(bus.oCen_b), 0);
    iRST_N = 1'b1;

    // Frame A: continuous input
    base = strobes.size();
    bb   = busyCnt;
    sendFrame(1'b0);
    idle(12);
    checkVal("A_count", strobes.size() - base, NSTROBE);
    checkVal("A_busy_cycles", busyCnt - bb, NBUSY);
    checkVal("A_busy_after", 32'(bus.oBusy), 0);
    checkHand("A_k0", base, {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0, 1'b1);
    checkHand("A_k5", base + 5, {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0}, 5, 1'b0);
`ifdef NOISE_WIN_FLUSH_EN
    checkHand("A_k11", base + 11, {8'd11, 8'd11, 8'd11, 8'd11, 8'd11, 8'd10, 8'd11, 8'd7, 8'd6}, 11, 1'b1);
`endif
    for (int i = 0; i < NSTROBE && base + i < strobes.size(); i++) begin
      checkWin($sformatf("A_win%0d", i), base + i, i);
      if (i + W + 1 < W * H)
        checkVal($sformatf("A_cyc%0d", i), strobes[base + i].cyc, beatEdge[i + W + 1]);
      else
        checkVal($sformatf("A_cyc%0d", i), strobes[base + i].cyc,
                 beatEdge[W * H - 1] + (i + W + 1 - (W * H - 1)));
    end

    // iDVAL without iSOF while idle is dropped
    base = strobes.size();
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, k);
    idle(8);
    checkVal("idle_drop", strobes.size() - base, 0);

    // Frame B: iDVAL every other cycle
    base = strobes.size();
    sendFrame(1'b1);
    idle(12);
    checkVal("B_count", strobes.size() - base, NSTROBE);
    for (int i = 0; i < NSTROBE && base + i < strobes.size(); i++) begin
      checkWin($sformatf("B_win%0d", i), base + i, i);
      if (i > 0 && i + W + 1 < W * H)
        checkVal($sformatf("B_gap%0d", i), strobes[base + i].cyc - strobes[base + i - 1].cyc, 2);
    end
    if (strobes.size() > base)
      checkVal("B_first_cyc", strobes[base].cyc, beatEdge[W + 1]);

    // Abort: new iSOF on what would have been beat 7
    base = strobes.size();
    for (int k = 0; k < 7; k++) drive(1'b1, k == 0, k);
    sendFrame(1'b0);
    idle(12);
    checkVal("ab_count", strobes.size() - base, 2 + NSTROBE);
    checkWin("ab_old0", base, 0);
    checkWin("ab_old1", base + 1, 1);
    for (int i = 0; i < NSTROBE && base + 2 + i < strobes.size(); i++)
      checkWin($sformatf("ab_new%0d", i), base + 2 + i, i);
    if (strobes.size() > base + 2)
      checkVal("ab_new_first_cyc", strobes[base + 2].cyc, beatEdge[W + 1]);

    // Reset asserted while running
    for (int k = 0; k < 8; k++) drive(1'b1, k == 0, k);
    @(posedge iCLK);
    #2;
    bus.iDVAL = 1'b0;
    checkVal("rr_pre_dval", 32'(bus.oDVAL), 1);
    iRST_N = 1'b0;
    #1;
    checkVal("rr_oDVAL", 32'(bus.oDVAL), 0);
    checkVal("rr_oW7", 32'(bus.oW7), 0);
    checkVal("rr_oCen_g", 32'(bus.oCen_g), 0);
    checkVal("rr_oBorder", 32'(bus.oBorder), 0);
    idle(2);
    iRST_N = 1'b1;
    base = strobes.size();
    for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, k);
    idle(6);
    checkVal("rr_idle_drop", strobes.size() - base, 0);
    base = strobes.size();
    sendFrame(1'b0);
    idle(12);
    checkVal("rr_count", strobes.size() - base, NSTROBE);
    checkWin("rr_first", base, 0);
    checkWin("rr_k5", base + 5, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noise_window_ctrl.md
# noise_window_ctrl

Streaming 3x3 window scheduler for the gray-level noise-filter stage of the real-time style-transfer pipeline. It accepts raster-order pixels (RGB plus precomputed gray) from the capture/gray stage and uses two line buffers to assemble, for every image pixel, the centre RGB and its 3x3 gray neighbourhood. It presents these to the combinational noise filter with a valid strobe and handles frame start, image borders and end-of-frame flush.

## Interface
- IMG_W, 640, pixels per line (≥4)
- IMG_H, 480, lines per frame (≥3)
- iCLK  in  1  pixel clock, rising edge
- iRST_N  in  1  asynchronous active-low reset
- iSOF  in  1  start of frame, qualified by iDVAL, marks pixel (0,0)
- iDVAL  in  1  input pixel valid (no backpressure)
- iR, iG, iB  in  8 each  input pixel colour
- iGray  in  8  input pixel gray level
- oDVAL  out  1  window valid, one-cycle strobe per centre pixel
- oCen_r, oCen_g, oCen_b  out  8 each  centre pixel RGB
- oW0..oW8  out  8 each  gray window, row-major, oW0 top-left, oW4 centre
- oBorder  out  1  centre lies on an image edge
- oBusy  out  1  high in FLUSH; iDVAL ignored while high

## Operation
- Counters col 0..IMG_W-1, row 0..IMG_H-1 advance on each accepted beat (iDVAL=1, oBusy=0); linear index k = row*IMG_W+col.
- Line buffer A (IMG_W × 32b) holds {R,G,B,Gray} of the previous line; line buffer B (IMG_W × 8b) holds gray of the line before that. Three 3-tap column shift registers (top/mid/bottom) form the window.
- Centre of index k is emitted on the beat accepting index k+IMG_W+1.
- Border rule: any tap outside the image is replaced by the centre gray; oBorder=1 if centre row ∈ {0,IMG_H-1} or col ∈ {0,IMG_W-1}. Taps never wrap across lines or frames.
- FSM states: IDLE → FILL on iSOF&iDVAL; FILL → RUN when k=IMG_W+1 accepted (first oDVAL); RUN → FLUSH after index IMG_W*IMG_H-1 accepted; FLUSH emits the remaining IMG_W+1 centres on consecutive cycles (bottom row replicated), then → IDLE.
- iSOF&iDVAL in FILL or RUN aborts the frame: counters reset, beat taken as (0,0), state FILL, no flush of the old frame.
- iSOF&iDVAL in FLUSH is ignored (oBusy=1); upstream guarantees ≥IMG_W+1 blank cycles between frames.
- iDVAL without prior iSOF in IDLE is dropped.

## Timing
- Reset: all outputs 0, state IDLE, counters 0; line buffer contents don't care (masked by border rule).
- oDVAL and all window outputs registered; asserted exactly one cycle after the completing input beat, held one cycle.
- In RUN, one oDVAL per accepted beat; gaps in iDVAL give matching gaps in oDVAL.
- Per frame exactly IMG_W*IMG_H oDVAL strobes (with flush enabled), in raster order.
- Line buffer reads are one-cycle latency; write and read of same address in one cycle returns old data.

## Configuration
- NOISE_WIN_FLUSH_EN defined: FLUSH state present as above.
- Not defined: RUN → IDLE directly after last input beat; the final IMG_W+1 centres are never emitted (IMG_W*IMG_H-IMG_W-1 strobes per frame); oBusy tied 0.

## Structure
- Package noise_win_pkg: FSM state enum (IDLE, FILL, RUN, FLUSH), PIX_W=8, counter width functions from IMG_W/IMG_H.
- Sub-module noise_win_linebuf: parameterised depth/width single-clock dual-port RAM with registered read, instantiated twice.

## Test plan
- IMG_W=4, IMG_H=3, gray=k, RGB={k,k+1,k+2}, continuous iDVAL → 12 strobes; first strobe one cycle after beat k=5 with oW0..oW8=0,0,0,0,0,1,0,4,5 (top/left replicated centre 0), oBorder=1.
- Same frame, centre k=5 → oW = 0,1,2,4,5,6,8,9,10, oCen={5,6,7}, oBorder=0.
- iDVAL toggling every other cycle → same 12 windows in order, oDVAL spaced 2 cycles.
- Flush: after k=11 accepted, 5 strobes on consecutive cycles with oBusy=1; last centre k=11 gives oW8=11 (replicated), then IDLE, oBusy=0.
- iSOF at k=7 mid-frame → no strobe for old frame's pending centres beyond those emitted; new frame's first strobe after its beat 5.
- Assert iRST_N low during RUN → outputs 0 immediately, IDLE; without NOISE_WIN_FLUSH_EN, a 4x3 frame yields exactly 7 strobes.
